// File: rtl/cpu_run_monitor.sv
// Run-control, trace and end-of-run register dump for the single-cycle CPU.
// Gates the CPU clock-enable, traces PC/inst, signs writebacks, dumps the RF.
module cpu_run_monitor #(
  parameter int PC_W       = 32,
  parameter int DATA_W     = 32,
  parameter int REG_CNT    = 32,
  parameter int MAX_CYCLES = 30,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PC_W-1:0]   pc,
  input  logic [31:0]       inst,
  input  logic              rf_we,
  input  logic [4:0]        rf_waddr,
  input  logic [DATA_W-1:0] rf_wdata,
  output logic              cpu_run,
  output logic              trace_valid,
  output logic [PC_W-1:0]   trace_pc,
  output logic [31:0]       trace_inst,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  wb_cnt,
  output logic [DATA_W-1:0] signature,
  output logic [4:0]        dump_addr,
  input  logic [DATA_W-1:0] dump_data,
  output logic              dump_valid,
  output logic [4:0]        dump_idx,
  output logic [DATA_W-1:0] dump_value,
  output logic [1:0]        halt_cause,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DUMP,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [4:0]      idx;
  logic [PC_W-1:0] prev_pc;
  logic            prev_pc_valid;
  logic            self_loop;
  logic            budget;
  logic            halt;
  logic            last;
  logic            wb_hit;

  assign self_loop = prev_pc_valid && (pc == prev_pc);
  assign budget    = cycle_cnt == CNT_W'(MAX_CYCLES - 1);
  assign halt      = self_loop || budget;
  assign last      = idx == 5'(REG_CNT - 1);
  assign wb_hit    = rf_we && (rf_waddr != 5'd0);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state: start only honoured when not busy.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (halt)  state_nx = DUMP;
      DUMP: if (last)  state_nx = DONE;
      DONE: if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // Decoded outputs; the CPU only advances while in RUN.
  always_comb begin
    cpu_run   = state == RUN;
    done      = state == DONE;
    dump_addr = idx;
  end

  // Run bookkeeping: trace, counters, signature, halt cause.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trace_valid   <= 1'b0;
      trace_pc      <= '0;
      trace_inst    <= '0;
      cycle_cnt     <= '0;
      wb_cnt        <= '0;
      signature     <= '0;
      halt_cause    <= 2'b00;
      prev_pc       <= '0;
      prev_pc_valid <= 1'b0;
    end else begin
      trace_valid <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            cycle_cnt     <= '0;
            wb_cnt        <= '0;
            signature     <= '0;
            halt_cause    <= 2'b00;
            prev_pc_valid <= 1'b0;
          end
        end
        RUN: begin
          trace_valid   <= 1'b1;
          trace_pc      <= pc;
          trace_inst    <= inst;
          cycle_cnt     <= cycle_cnt + 1'b1;
          prev_pc       <= pc;
          prev_pc_valid <= 1'b1;
          if (wb_hit) begin
            wb_cnt    <= wb_cnt + 1'b1;
            signature <= {signature[DATA_W-2:0], signature[DATA_W-1]}
                         ^ rf_wdata ^ DATA_W'(rf_waddr);
          end
          if (halt) halt_cause <= self_loop ? 2'b10 : 2'b01;
        end
        default: ;
      endcase
    end
  end

  // Dump walker: index reset on halt, one register per cycle in DUMP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx        <= '0;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_value <= '0;
    end else begin
      dump_valid <= 1'b0;
      if (state == RUN && halt) idx <= '0;
      if (state == DUMP) begin
        dump_valid <= 1'b1;
        dump_idx   <= idx;
        dump_value <= dump_data;
        idx        <= idx + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: random programs, scoreboarded trace/dump.
// Reference model derives halt point, counters and records from run rules.
module tb_cpu_run_monitor;
  localparam int PW = 32;
  localparam int DW = 32;
  localparam int RC = 32;
  localparam int MC = 30;
  localparam int CW = 16;
  localparam int N  = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [PW-1:0] pc = '0;
  logic [31:0]   inst = '0;
  logic          rf_we = 1'b0;
  logic [4:0]    rf_waddr = '0;
  logic [DW-1:0] rf_wdata = '0;
  logic          cpu_run;
  logic          trace_valid;
  logic [PW-1:0] trace_pc;
  logic [31:0]   trace_inst;
  logic [CW-1:0] cycle_cnt;
  logic [CW-1:0] wb_cnt;
  logic [DW-1:0] signature;
  logic [4:0]    dump_addr;
  logic [DW-1:0] dump_data;
  logic          dump_valid;
  logic [4:0]    dump_idx;
  logic [DW-1:0] dump_value;
  logic [1:0]    halt_cause;
  logic          done;

  cpu_run_monitor #(
    .PC_W(PW), .DATA_W(DW), .REG_CNT(RC),
    .MAX_CYCLES(MC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .pc(pc), .inst(inst),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .cpu_run(cpu_run),
    .trace_valid(trace_valid), .trace_pc(trace_pc),
    .trace_inst(trace_inst),
    .cycle_cnt(cycle_cnt), .wb_cnt(wb_cnt), .signature(signature),
    .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_valid(dump_valid), .dump_idx(dump_idx),
    .dump_value(dump_value),
    .halt_cause(halt_cause), .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] regs [RC];
  assign dump_data = regs[dump_addr];

  logic [31:0] pc_a [N];
  logic [31:0] in_a [N];
  logic [31:0] wd_a [N];
  logic [4:0]  wa_a [N];
  logic        we_a [N];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } rec_t;
  rec_t trq[$];
  rec_t dmq[$];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: pops an expectation whenever a record appears.
  always @(negedge clk) begin
    rec_t r;
    if (rst) begin
      if (trace_valid) begin
        check("trace_pending", 64'(trq.size() > 0), 64'd1);
        if (trq.size() > 0) begin
          r = trq.pop_front();
          check("trace_pc", 64'(trace_pc), 64'(r.a));
          check("trace_inst", 64'(trace_inst), 64'(r.b));
        end
      end
      if (dump_valid) begin
        check("dump_pending", 64'(dmq.size() > 0), 64'd1);
        if (dmq.size() > 0) begin
          r = dmq.pop_front();
          check("dump_idx", 64'(dump_idx), 64'(r.a));
          check("dump_value", 64'(dump_value), 64'(r.b));
        end
        if (dump_idx == 5'(RC - 1))
          check("done_at_last", 64'(done), 64'd1);
      end
    end
  end

  task automatic fill_linear();
    for (int k = 0; k < N; k++) begin
      pc_a[k] = 32'h3000 + 32'(4 * k);
      in_a[k] = $urandom;
      we_a[k] = 1'($urandom_range(0, 1));
      wa_a[k] = 5'($urandom_range(0, 31));
      wd_a[k] = $urandom;
    end
  endtask

  task automatic check_zero();
    check("rst_run", 64'(cpu_run), 64'd0);
    check("rst_trace", 64'({trace_valid, trace_pc, trace_inst}), 64'd0);
    check("rst_cnt", 64'({cycle_cnt, wb_cnt}), 64'd0);
    check("rst_sig", 64'(signature), 64'd0);
    check("rst_dump", 64'({dump_valid, dump_idx, dump_value}), 64'd0);
    check("rst_misc", 64'({halt_cause, done, dump_addr}), 64'd0);
  endtask

  task automatic run(int abort_idx);
    int h;
    int cause;
    int wb;
    int k;
    int g;
    logic [31:0] sig;
    h = -1; cause = 0; wb = 0; sig = 0;
    for (int j = 0; j < N && h < 0; j++) begin
      if (j > 0 && pc_a[j] == pc_a[j-1]) begin h = j; cause = 2; end
      else if (j == MC - 1) begin h = j; cause = 1; end
    end
    for (int j = 0; j <= h; j++) begin
      trq.push_back('{pc_a[j], in_a[j]});
      if (we_a[j] && wa_a[j] != 0) begin
        wb++;
        sig = ((sig << 1) | (sig >> 31)) ^ wd_a[j] ^ 32'(wa_a[j]);
      end
    end
    for (int i = 0; i < RC; i++) begin
      regs[i] = $urandom;
      dmq.push_back('{32'(i), regs[i]});
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("entry_run", 64'(cpu_run), 64'd1);
    check("entry_cnt", 64'({cycle_cnt, wb_cnt}), 64'd0);
    check("entry_sig", 64'(signature), 64'd0);
    check("entry_cause", 64'({halt_cause, done}), 64'd0);
    k = 0;
    while (cpu_run && k < N) begin
      pc = pc_a[k]; inst = in_a[k];
      rf_we = we_a[k]; rf_waddr = wa_a[k]; rf_wdata = wd_a[k];
      start = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    rf_we = 1'b1; rf_waddr = 5'd7; rf_wdata = $urandom;
    check("cpu_steps", 64'(k), 64'(h + 1));
    check("halt_cnt", 64'(cycle_cnt), 64'(h + 1));
    check("halt_cause", 64'(halt_cause), 64'(cause));
    if (abort_idx >= 0) begin
      g = 0;
      while (!(dump_valid && dump_idx == 5'(abort_idx)) && g < 100) begin
        @(negedge clk); g++;
      end
      check("abort_reached", 64'(g < 100), 64'd1);
      rst = 1'b0;
      #1;
      check_zero();
      trq.delete();
      dmq.delete();
      @(negedge clk) rst = 1'b1;
      rf_we = 1'b0;
      return;
    end
    g = 0;
    while (!done && g < RC + 5) begin
      @(negedge clk); g++;
    end
    check("done_reached", 64'(done), 64'd1);
    @(negedge clk);
    rf_we = 1'b0;
    check("post_dump_valid", 64'({dump_valid, trace_valid}), 64'd0);
    check("done_hold", 64'(done), 64'd1);
    check("trq_empty", 64'(trq.size()), 64'd0);
    check("dmq_empty", 64'(dmq.size()), 64'd0);
    check("final_cnt", 64'(cycle_cnt), 64'(h + 1));
    check("final_wb", 64'(wb_cnt), 64'(wb));
    check("final_sig", 64'(signature), 64'(sig));
    check("final_cause", 64'(halt_cause), 64'(cause));
  endtask

  initial begin
    for (int i = 0; i < RC; i++) regs[i] = 32'(i * 32'h11);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_zero();
    rst = 1'b1;

    fill_linear();
    run(-1);

    fill_linear();
    pc_a[3] = 32'h3008;
    run(-1);

    fill_linear();
    pc_a[3] = 32'h3008;
    for (int k = 0; k < N; k++) we_a[k] = 1'b0;
    we_a[0] = 1'b1; wa_a[0] = 5'd8; wd_a[0] = 32'h5;
    we_a[1] = 1'b1; wa_a[1] = 5'd0; wd_a[1] = 32'hFFFF;
    we_a[2] = 1'b1; wa_a[2] = 5'd9; wd_a[2] = 32'hA;
    run(-1);
    check("sig_directed", 64'(signature), 64'h19);
    check("wb_directed", 64'(wb_cnt), 64'd2);

    fill_linear();
    pc_a[MC-1] = pc_a[MC-2];
    run(-1);

    fill_linear();
    run(3);
    fill_linear();
    run(-1);

    for (int r = 0; r < 4; r++) begin
      fill_linear();
      for (int k = 1; k < N; k++)
        if ($urandom_range(0, 9) == 0) pc_a[k] = pc_a[k-1];
      run(-1);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/cpu_run_monitor.md
# cpu_run_monitor

Run-control, trace and end-of-run dump block for the single-cycle CPU. It sits beside the CPU in simulation and FPGA bring-up builds. It gates CPU execution through a clock-enable, emits a per-cycle PC/instruction trace, and keeps a writeback counter and signature. On halt (cycle budget exhausted or PC self-loop) it walks the register file through a read port and streams out every register.

## Interface
- PC_W, 32, PC width
- DATA_W, 32, register data width
- REG_CNT, 32, registers dumped (indices 0..REG_CNT-1, REG_CNT ≤ 32)
- MAX_CYCLES, 30, run-cycle budget (≥1)
- CNT_W, 16, counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin a run; honoured in IDLE and DONE only
- pc  in  PC_W  current CPU PC
- inst  in  32  current CPU instruction
- rf_we  in  1  CPU register-file write enable
- rf_waddr  in  5  CPU write address
- rf_wdata  in  DATA_W  CPU write data
- cpu_run  out  1  CPU clock-enable; high only in RUN
- trace_valid, trace_pc, trace_inst  out  1/PC_W/32  registered trace record
- cycle_cnt  out  CNT_W  RUN cycles completed
- wb_cnt  out  CNT_W  writes to registers ≠ 0
- signature  out  DATA_W  writeback signature
- dump_addr  out  5  register-file read address (combinational from dump index)
- dump_data  in  DATA_W  combinational register read data
- dump_valid, dump_idx, dump_value  out  1/5/DATA_W  registered dump record
- halt_cause  out  2  00 none, 01 cycle budget, 10 self-loop
- done  out  1  high in DONE

## Operation
- States: IDLE, RUN, DUMP, DONE. Reset forces IDLE and zeroes every output and internal register, including prev_pc_valid. Reset takes effect immediately, including mid-RUN or mid-DUMP.
- IDLE, on start: go to RUN. Clear cycle_cnt, wb_cnt, signature, halt_cause and prev_pc_valid.
- DONE, on start: same clearing as from IDLE, then go to RUN. start in RUN or DUMP is ignored.
- Each RUN cycle, at the rising edge:
  - trace_valid←1, trace_pc←pc, trace_inst←inst.
  - cycle_cnt←cycle_cnt+1.
  - prev_pc←pc, prev_pc_valid←1.
  - If rf_we and rf_waddr≠0: wb_cnt+1, and signature←rotl(signature,1) ^ rf_wdata ^ zero-extended rf_waddr. Arithmetic wraps modulo 2^width.
- Halt evaluation in a RUN cycle:
  - Self-loop: prev_pc_valid and pc==prev_pc.
  - Budget: cycle_cnt==MAX_CYCLES-1.
  - If both hold, self-loop wins (halt_cause=10).
  - On halt: latch halt_cause, go to DUMP, dump index←0. The halting cycle is still traced, counted and observed for writeback.
- DUMP:
  - dump_addr = index.
  - Each edge: dump_valid←1, dump_idx←index, dump_value←dump_data, index+1.
  - After the edge for index REG_CNT-1, go to DONE.
- Outside RUN, trace_valid←0. Outside DUMP, dump_valid←0 at the next edge.
- Counters, signature and halt_cause hold their values in DUMP and DONE.

## Timing
- Trace latency is 1 cycle: the record for RUN cycle k is visible during cycle k+1.
- cpu_run is combinational from state, so the CPU advances exactly cycle_cnt instructions.
- Dump takes exactly REG_CNT cycles. The last record (dump_valid=1, dump_idx=REG_CNT-1) coincides with the first DONE cycle, where done=1. dump_valid drops one cycle later.
- Cycle count at halt:
  - Budget halt: cycle_cnt=MAX_CYCLES.
  - Self-loop halt: cycle_cnt equals the RUN cycles executed, including the repeated-PC cycle.
- An rf_we in the halting cycle is counted. CPU writes outside RUN are ignored.

## Test plan
- Budget halt: MAX_CYCLES=30, PC sequence 0x3000,0x3004,… never repeats → 30 trace records with pc 0x3000..0x3074, cycle_cnt=30, halt_cause=01, then 32 dump records idx 0..31, done=1.
- Self-loop: PC 0x3000,0x3004,0x3008,0x3008 → halt after 4th cycle, cycle_cnt=4, halt_cause=10, trace shows 0x3008 twice. Repeat with MAX_CYCLES=4 → halt_cause still 10.
- Signature/wb_cnt: writes (r8,0x5),(r0,0xFFFF),(r9,0xA) → wb_cnt=2, signature=rotl(0x0000000D,1)^0xA^0x9=0x00000019.
- Dump correctness: register model with r[i]=i*0x11 and REG_CNT=8 → dump_value 0x00,0x11,…,0x77 on consecutive cycles, idx 0..7, done in the cycle of idx 7.
- Reset mid-DUMP at idx 3 → all outputs 0 and state IDLE immediately. A following start gives a fresh run with counters from 0.
- Restart from DONE: start pulse → cycle_cnt, wb_cnt, signature, halt_cause cleared, cpu_run=1 in the next cycle. A start asserted during RUN has no effect.
